// File: rtl/wb_arbiter_pkg.sv
// Shared CPU constants for the write-back arbiter.
// Requester indices and round-robin priority encodings.
package wb_arbiter_pkg;

    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;
    localparam int REQ_MD  = 2;

    localparam logic [0:0] PRI_LD = 1'b0;
    localparam logic [0:0] PRI_MD = 1'b1;

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back requester, register-file write and scoreboard signals.
// The arbiter takes the slave side; requesters/decode take master.
interface wb_arbiter_if;

    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;

    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;

    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;

    logic        fg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    logic        sb_set;
    logic [4:0]  sb_addr;

    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        busy1;
    logic        busy2;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        output ld_ready,
        input  md_valid, md_addr, md_data,
        output md_ready,
        output fg_write, write_addr, write_data,
        input  sb_set, sb_addr,
        input  chk_addr1, chk_addr2,
        output busy1, busy2
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        input  ld_ready,
        output md_valid, md_addr, md_data,
        input  md_ready,
        input  fg_write, write_addr, write_data,
        output sb_set, sb_addr,
        output chk_addr1, chk_addr2,
        input  busy1, busy2
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, x0 never pending.
// A set and a clear to the same register in one cycle leaves it set.
module wb_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic [4:0] chk_addr1,
    input  logic [4:0] chk_addr2,
    output logic       busy1,
    output logic       busy2
);

    logic [31:0] pending;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_addr] = 1'b1;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
        end
    end

    assign busy1 = pending[chk_addr1];
    assign busy2 = pending[chk_addr2];

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU has fixed priority, LOAD/MULDIV share the
// port round-robin; the winner is registered onto the write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);

    logic [0:0]      state;
    logic [NREQ-1:0] grant;
    logic            ld_win;
    logic            md_win;
    logic [4:0]      wr_addr;
    logic [31:0]     wr_data;
    logic            wr_en;
    logic            clr_en;

    logic            fg_write_q;
    logic [4:0]      write_addr_q;
    logic [31:0]     write_data_q;

    assign ld_win = (state == PRI_LD) || !bus.md_valid;
    assign md_win = (state == PRI_MD) || !bus.ld_valid;

    always_comb begin
        grant = '0;
        if (!rst) begin
            grant[REQ_ALU] = bus.alu_valid;
            if (!bus.alu_valid) begin
                grant[REQ_LD] = bus.ld_valid && ld_win;
                grant[REQ_MD] = bus.md_valid && md_win;
            end
        end
    end

    assign bus.ld_ready = grant[REQ_LD];
    assign bus.md_ready = grant[REQ_MD];

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        if (grant[REQ_ALU]) begin
            wr_addr = bus.alu_addr;
            wr_data = bus.alu_data;
        end else if (grant[REQ_LD]) begin
            wr_addr = bus.ld_addr;
            wr_data = bus.ld_data;
        end else if (grant[REQ_MD]) begin
            wr_addr = bus.md_addr;
            wr_data = bus.md_data;
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    assign wr_en  = (|grant) && (wr_addr != 5'd0);
    assign clr_en = grant[REQ_LD] || grant[REQ_MD];

    always_ff @(posedge clk) begin
        if (rst) begin
            fg_write_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            state        <= PRI_LD;
        end else begin
            fg_write_q <= wr_en;
            if (wr_en) begin
                write_addr_q <= wr_addr;
                write_data_q <= wr_data;
            end
            if (grant[REQ_LD]) begin
                state <= PRI_MD;
            end else if (grant[REQ_MD]) begin
                state <= PRI_LD;
            end
        end
    end

    assign bus.fg_write   = fg_write_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;

    wb_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (bus.sb_set),
        .set_addr  (bus.sb_addr),
        .clr_en    (clr_en),
        .clr_addr  (wr_addr),
        .chk_addr1 (bus.chk_addr1),
        .chk_addr2 (bus.chk_addr2),
        .busy1     (bus.busy1),
        .busy2     (bus.busy2)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: priority, round-robin, scoreboard
// and reset behaviour against hand-computed values.
module tb_wb_arbiter;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    wb_arbiter_if bus ();

    wb_arbiter #(.NREQ(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.md_valid  = 1'b0;
        bus.sb_set    = 1'b0;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h11;
        bus.ld_valid  = 1'b1; bus.ld_addr  = 5'd4; bus.ld_data  = 32'h44;
        bus.md_valid  = 1'b1; bus.md_addr  = 5'd6; bus.md_data  = 32'h66;
        bus.sb_set    = 1'b1; bus.sb_addr  = 5'd7;
        bus.chk_addr1 = 5'd7; bus.chk_addr2 = 5'd0;

        // reset state
        tick(); tick();
        chk("rst_fg_write", 32'(bus.fg_write), 32'd0);
        chk("rst_addr", 32'(bus.write_addr), 32'd0);
        chk("rst_data", bus.write_data, 32'd0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("rst_md_ready", 32'(bus.md_ready), 32'd0);
        chk("rst_busy1", 32'(bus.busy1), 32'd0);
        idle();
        rst = 1'b0;
        tick();
        chk("post_rst_fg_write", 32'(bus.fg_write), 32'd0);

        // ALU priority over LOAD
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h11;
        bus.ld_valid  = 1'b1; bus.ld_addr  = 5'd4; bus.ld_data  = 32'h44;
        #1;
        chk("alu_pri_ld_ready", 32'(bus.ld_ready), 32'd0);
        tick();
        chk("alu_fg_write", 32'(bus.fg_write), 32'd1);
        chk("alu_addr", 32'(bus.write_addr), 32'd3);
        chk("alu_data", bus.write_data, 32'h11);
        chk("alu_hold_ld_ready", 32'(bus.ld_ready), 32'd0);
        bus.alu_valid = 1'b0;
        #1;
        chk("ld_ready_after_alu", 32'(bus.ld_ready), 32'd1);
        tick();
        chk("ld_addr", 32'(bus.write_addr), 32'd4);
        chk("ld_data", bus.write_data, 32'h44);
        bus.ld_valid = 1'b0;
        tick();
        chk("idle_fg_write", 32'(bus.fg_write), 32'd0);
        chk("idle_addr_hold", 32'(bus.write_addr), 32'd4);

        // round-robin from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd5; bus.ld_data = 32'h55;
        bus.md_valid = 1'b1; bus.md_addr = 5'd6; bus.md_data = 32'h66;
        #1;
        chk("rr0_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("rr0_md_ready", 32'(bus.md_ready), 32'd0);
        tick();
        chk("rr1_addr", 32'(bus.write_addr), 32'd5);
        chk("rr1_md_ready", 32'(bus.md_ready), 32'd1);
        chk("rr1_ld_ready", 32'(bus.ld_ready), 32'd0);
        tick();
        chk("rr2_addr", 32'(bus.write_addr), 32'd6);
        chk("rr2_data", bus.write_data, 32'h66);
        tick();
        chk("rr3_addr", 32'(bus.write_addr), 32'd5);
        tick();
        chk("rr4_addr", 32'(bus.write_addr), 32'd6);
        chk("rr4_fg_write", 32'(bus.fg_write), 32'd1);
        idle();
        tick();

        // scoreboard set, then cleared by MULDIV accept
        bus.sb_set = 1'b1; bus.sb_addr = 5'd7;
        tick();
        bus.sb_set = 1'b0;
        bus.chk_addr1 = 5'd7;
        #1;
        chk("sb7_busy1", 32'(bus.busy1), 32'd1);
        bus.md_valid = 1'b1; bus.md_addr = 5'd7; bus.md_data = 32'h77;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h1;
        #1;
        chk("alu_pri_md_ready", 32'(bus.md_ready), 32'd0);
        tick();
        chk("alu7_keeps_busy1", 32'(bus.busy1), 32'd1);
        bus.alu_valid = 1'b0;
        tick();
        chk("md7_clr_busy1", 32'(bus.busy1), 32'd0);
        chk("md7_addr", 32'(bus.write_addr), 32'd7);
        chk("md7_data", bus.write_data, 32'h77);
        bus.md_valid = 1'b0;

        // set wins over clear on the same register
        bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd9; bus.ld_data = 32'h99;
        bus.chk_addr2 = 5'd9;
        tick();
        chk("sb9_busy2", 32'(bus.busy2), 32'd1);
        chk("ld9_addr", 32'(bus.write_addr), 32'd9);
        idle();
        tick();
        chk("sb9_busy2_hold", 32'(bus.busy2), 32'd1);

        // write to x0 dropped, x0 never pending
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd0; bus.ld_data = 32'hFF;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
        bus.chk_addr1 = 5'd0;
        #1;
        chk("x0_ld_ready", 32'(bus.ld_ready), 32'd1);
        tick();
        chk("x0_fg_write", 32'(bus.fg_write), 32'd0);
        chk("x0_addr_hold", 32'(bus.write_addr), 32'd9);
        chk("x0_data_hold", bus.write_data, 32'h99);
        chk("x0_busy1", 32'(bus.busy1), 32'd0);
        idle();

        // reset after an accept, then LOAD wins the next contest
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd10; bus.ld_data = 32'hA;
        tick();
        chk("pre_rst_fg_write", 32'(bus.fg_write), 32'd1);
        bus.ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_fg_write", 32'(bus.fg_write), 32'd0);
        chk("mid_rst_busy2", 32'(bus.busy2), 32'd0);
        chk("mid_rst_busy1", 32'(bus.busy1), 32'd0);
        rst = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd12; bus.ld_data = 32'hC;
        bus.md_valid = 1'b1; bus.md_addr = 5'd13; bus.md_data = 32'hD;
        #1;
        chk("post_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("post_rst_md_ready", 32'(bus.md_ready), 32'd0);
        tick();
        chk("post_rst_addr", 32'(bus.write_addr), 32'd12);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
